wb_arbiter: RTL
===============

# wb_arbiter

- Shares the three result-writeback buses (wb1/wb2/wb3) among four fire-and-forget producers: ALU RS, MUL RS, DIV RS (divider unit) and LSB.
- Per-source result FIFOs buffer results; a round-robin scheduler drains up to three FIFOs per cycle onto registered writeback buses.
- Producers are throttled through a registered stall flag.
- The wb buses fan out to every reservation station's writeback1/2/3 inputs and to the ROB.

## Interface

Parameters:
- DEPTH, 4, entries per source FIFO (power of two, ≥2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush (mispredict); discards all buffered results.
- src_en[3:0]  input  4  per-source result valid; index 0=ALU, 1=MUL, 2=DIV, 3=LSB.
- src_vregid[4*5-1:0]  input  20  per-source destination vreg id; source i occupies bits [5i+4:5i].
- src_val[4*32-1:0]  input  128  per-source result value; source i occupies bits [32i+31:32i].
- stall[3:0]  output  4  registered; source i must not start new operations while set.
- overflow_err  output  1  sticky; set when a result is dropped.
- wb1_en, wb2_en, wb3_en  output  1 each  registered bus valid.
- wb1_vregid, wb2_vregid, wb3_vregid  output  5 each  registered bus vreg id.
- wb1_val, wb2_val, wb3_val  output  32 each  registered bus value.

## Operation

**FIFOs**
- One circular FIFO per source: DEPTH entries of {vregid, val}.
- Each FIFO has a rd_ptr and a wr_ptr, log2(DEPTH) bits wide, which wrap naturally.
- Each FIFO has a count, log2(DEPTH)+1 bits wide.

**Push**
- A push occurs on src_en[i] when count_i < DEPTH, or when count_i == DEPTH and source i is popped this same cycle.
- A push onto a FIFO that is full and not being popped is dropped, and overflow_err is set.
- A push and a pop on the same FIFO in the same cycle leave count_i unchanged.

**Scheduler**
- Combinational scan over sources rr, rr+1, rr+2, rr+3 (mod 4), using count_i > 0 from the pre-edge state.
- The first three non-empty sources found are granted.
- Grant k (k = 1, 2, 3) pops its FIFO head onto bus wbk.
- Buses left without a grant drive en=0; their vregid and val hold their previous values.
- A same-cycle input never bypasses the FIFO; it is not visible to the scan.

**Round-robin pointer**
- rr ← (index of last granted source + 1) mod 4.
- rr is unchanged when nothing is granted.
- Fairness guarantee: no non-empty FIFO waits more than one cycle.

**Stall**
- stall[i] ← (next count_i ≥ DEPTH−1).
- This leaves one slot of slack for an operation already committed in the producer's final stage.

**Flush**
- On the edge where flush=1: all counts, rd_ptr and wr_ptr ← 0.
- Same edge: wb*_en ← 0, stall ← 0, rr ← 0.
- Same edge: src_en inputs are ignored and no pop occurs.
- overflow_err is not cleared by flush.

**Reset**
- While rst=0, regardless of clk: counts, pointers and rr ← 0.
- wb*_en, wb*_vregid, wb*_val ← 0.
- stall ← 0, overflow_err ← 0.
- FIFO data storage need not be reset.

**Arithmetic**
- All pointer and rr arithmetic is modulo its width.
- Values pass through unmodified.

## Timing

- Result sampled on edge k: it is in the FIFO after edge k.
- Earliest wb*_en=1 for it is the cycle after edge k+1: 2-edge minimum latency.
- Worst-case latency under full load is bounded by FIFO depth × 4/3 cycles plus 1.
- Bus assignment is positional, not per source. The same source may appear on different buses in different cycles.
- At most one pop per source per cycle; at most three sources drained per cycle.
- A fourth non-empty source waits until the next cycle, where it is scanned first.
- stall is registered, so it reflects the count after the current edge.
- A producer seeing stall=0 in cycle c may deliver one result at edge c+1 safely.
- Reset deassertion: the first push is accepted on the first rising edge with rst=1.

## Test plan

1. **Reset mid-burst:** with all FIFOs holding 3 entries, assert rst=0 for 1 cycle, then release.
   - Required: all wb*_en=0 and stall=0 immediately.
   - Required: the first new result pushed after release appears on wb1 with latency 2.
2. **Single source:** DIV pushes {vreg 5, 0x0000_0007} at edge 0.
   - Required: wb1_en=1, wb1_vregid=5, wb1_val=7 in the cycle after edge 1.
   - Required: wb2_en=wb3_en=0 in that cycle.
3. **Four-way contention:** all four sources push one result at edge 0, with rr=0.
   - Required after edge 1: sources 0/1/2 on wb1/wb2/wb3, and rr=3.
   - Required after edge 2: source 3 on wb1.
4. **Saturation:** ALU pushes every cycle from empty, with the other three FIFOs each holding DEPTH entries.
   - Required: stall[0] rises when ALU count reaches 3.
   - Required: no drop occurs if the ALU stops the cycle after stall is seen.
   - Required: overflow_err stays 0.
5. **Overflow:** push into a full, unpopped FIFO.
   - Required: the value is dropped (never appears on any bus).
   - Required: overflow_err=1 and stays 1 after a flush.
6. **Flush collision:** flush=1 on the same edge as pushes from all sources.
   - Required: all counts=0 and wb*_en=0 after that edge.
   - Required: none of those pushed values ever appears on any bus.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: four per-source result FIFOs drained round-robin onto three
// registered writeback buses, with registered per-source stall and sticky overflow.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [3:0]   src_en,
    input  logic [19:0]  src_vregid,
    input  logic [127:0] src_val,
    output logic [3:0]   stall,
    output logic         overflow_err,
    output logic         wb1_en,
    output logic         wb2_en,
    output logic         wb3_en,
    output logic [4:0]   wb1_vregid,
    output logic [4:0]   wb2_vregid,
    output logic [4:0]   wb3_vregid,
    output logic [31:0]  wb1_val,
    output logic [31:0]  wb2_val,
    output logic [31:0]  wb3_val
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  vreg;
        logic [31:0] val;
    } ent_t;

    ent_t          mem_q [4][DEPTH];
    logic [PW-1:0] rd_q  [4];
    logic [PW-1:0] wr_q  [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [1:0]    rr_q, rr_d;
    logic [3:0]    stall_q;
    logic          ovf_q, ovf_d;
    logic [2:0]    ben_q, ben_d;
    ent_t          bus_q [3];
    ent_t          bus_d [3];
    logic [1:0]    bsrc  [3];
    logic [3:0]    pop, push;

    // Scan from rr; the first three non-empty FIFOs take buses 1..3 in scan order.
    always_comb begin
        logic [1:0] idx;
        logic [1:0] ng;
        pop   = '0;
        ben_d = '0;
        bsrc  = '{default: '0};
        rr_d  = rr_q;
        ng    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (cnt_q[idx] != '0 && ng != 2'd3) begin
                pop[idx]  = 1'b1;
                ben_d[ng] = 1'b1;
                bsrc[ng]  = idx;
                rr_d      = idx + 2'd1;
                ng        = ng + 2'd1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            bus_d[b] = bus_q[b];
            if (ben_d[b]) bus_d[b] = mem_q[bsrc[b]][rd_q[bsrc[b]]];
        end
    end

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            push[i]  = src_en[i] && (cnt_q[i] != CW'(DEPTH) || pop[i]);
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
        ovf_d = ovf_q | (|(src_en & ~push));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (push[i] && !flush)
                mem_q[i][wr_q[i]] <= '{vreg: src_vregid[5*i +: 5], val: src_val[32*i +: 32]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
            end
            rr_q    <= '0;
            stall_q <= '0;
            ovf_q   <= 1'b0;
            ben_q   <= '0;
            bus_q   <= '{default: '0};
        end else if (flush) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
            end
            rr_q    <= '0;
            stall_q <= '0;
            ben_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]   <= cnt_d[i];
                stall_q[i] <= cnt_d[i] >= CW'(DEPTH - 1);
                if (push[i]) wr_q[i] <= wr_q[i] + PW'(1);
                if (pop[i])  rd_q[i] <= rd_q[i] + PW'(1);
            end
            rr_q  <= rr_d;
            ovf_q <= ovf_d;
            ben_q <= ben_d;
            bus_q <= bus_d;
        end
    end

    assign stall        = stall_q;
    assign overflow_err = ovf_q;
    assign wb1_en       = ben_q[0];
    assign wb2_en       = ben_q[1];
    assign wb3_en       = ben_q[2];
    assign wb1_vregid   = bus_q[0].vreg;
    assign wb2_vregid   = bus_q[1].vreg;
    assign wb3_vregid   = bus_q[2].vreg;
    assign wb1_val      = bus_q[0].val;
    assign wb2_val      = bus_q[1].val;
    assign wb3_val      = bus_q[2].val;
endmodule
